// File: rtl/ub_affine_op_controller_if.sv
// Request/config and strobe/status bundle between a unified-buffer op port and its sequencer.
// UB_CTRL_STALL_EN adds the stall request to the bundle.
interface ub_affine_op_controller_if #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned TIME_W = 32
);
  logic                     flush;
  logic                     start;
  logic [2:0][CTRL_W-1:0]   cfg_extent;
  logic [2:0][TIME_W-1:0]   cfg_stride;
  logic [TIME_W-1:0]        cfg_offset;
  logic                     en;
  logic [2:0][CTRL_W-1:0]   ctrl_vars;
  logic                     busy;
  logic                     done;
  logic                     cfg_err;

`ifdef UB_CTRL_STALL_EN
  logic                     stall;

  modport master (output flush, start, cfg_extent, cfg_stride, cfg_offset, stall,
                  input  en, ctrl_vars, busy, done, cfg_err);
  modport slave  (input  flush, start, cfg_extent, cfg_stride, cfg_offset, stall,
                  output en, ctrl_vars, busy, done, cfg_err);
`else
  modport master (output flush, start, cfg_extent, cfg_stride, cfg_offset,
                  input  en, ctrl_vars, busy, done, cfg_err);
  modport slave  (input  flush, start, cfg_extent, cfg_stride, cfg_offset,
                  output en, ctrl_vars, busy, done, cfg_err);
`endif
endinterface

// File: rtl/ub_affine_op_controller.sv
// Walks a 3-deep loop nest and strobes one unified-buffer op port on an affine cycle schedule.
// Optional UB_CTRL_STALL_EN: a stall input freezes the schedule while a run is in progress.
module ub_affine_op_controller #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned TIME_W = 32
) (
  input logic                      clk,
  input logic                      rst_n,
  ub_affine_op_controller_if.slave ctrl
);

  localparam int unsigned SUM_W = TIME_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic [TIME_W-1:0]      t_q, t_d;
  logic [TIME_W-1:0]      nf_q, nf_d;
  logic [1:0][TIME_W-1:0] base_q, base_d;
  logic [2:0][TIME_W-1:0] stride_q, stride_d;
  logic [2:0][CTRL_W-1:0] ext_q, ext_d;
  logic [2:0][CTRL_W-1:0] idx_q, idx_d;
  logic [2:0][CTRL_W-1:0] cv_q, cv_d;
  logic                   en_q, en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   stall_c;
  logic                   cfg_zero_c;
  logic                   ext_zero_c;
  logic [2:0]             at_end_c;
  logic [SUM_W-1:0]       sum_c;

`ifdef UB_CTRL_STALL_EN
  assign stall_c = ctrl.stall;
`else
  assign stall_c = 1'b0;
`endif

  assign cfg_zero_c = (ctrl.cfg_extent[0] == '0) || (ctrl.cfg_extent[1] == '0) ||
                      (ctrl.cfg_extent[2] == '0);
  assign ext_zero_c = (ext_q[0] == '0) || (ext_q[1] == '0) || (ext_q[2] == '0);
  assign at_end_c[0] = (idx_q[0] == (ext_q[0] - CTRL_W'(1)));
  assign at_end_c[1] = (idx_q[1] == (ext_q[1] - CTRL_W'(1)));
  assign at_end_c[2] = (idx_q[2] == (ext_q[2] - CTRL_W'(1)));

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    nf_d     = nf_q;
    base_d   = base_q;
    stride_d = stride_q;
    ext_d    = ext_q;
    idx_d    = idx_q;
    cv_d     = cv_q;
    en_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    sum_c    = '0;

    case (state_q)
      IDLE: begin
        if (ctrl.start) begin
          ext_d    = ctrl.cfg_extent;
          stride_d = ctrl.cfg_stride;
          t_d      = '0;
          idx_d    = '0;
          nf_d     = ctrl.cfg_offset;
          base_d   = {ctrl.cfg_offset, ctrl.cfg_offset};
          err_d    = 1'b0;
          busy_d   = !cfg_zero_c;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (ext_zero_c) begin
          state_d = DONE;
        end else if (!stall_c) begin
          t_d = t_q + TIME_W'(1);
          if (t_q == nf_q) begin
            en_d = 1'b1;
            cv_d = idx_q;
            if (&at_end_c) begin
              state_d = DONE;
            end else begin
              // Odometer advance; the add is one bit wider so overflow is caught as a violation.
              if (!at_end_c[2]) begin
                idx_d[2] = idx_q[2] + CTRL_W'(1);
                sum_c    = SUM_W'(nf_q) + SUM_W'(stride_q[2]);
              end else if (!at_end_c[1]) begin
                idx_d[2]  = '0;
                idx_d[1]  = idx_q[1] + CTRL_W'(1);
                sum_c     = SUM_W'(base_q[1]) + SUM_W'(stride_q[1]);
                base_d[1] = sum_c[TIME_W-1:0];
              end else begin
                idx_d[2]  = '0;
                idx_d[1]  = '0;
                idx_d[0]  = idx_q[0] + CTRL_W'(1);
                sum_c     = SUM_W'(base_q[0]) + SUM_W'(stride_q[0]);
                base_d[0] = sum_c[TIME_W-1:0];
                base_d[1] = sum_c[TIME_W-1:0];
              end
              nf_d = sum_c[TIME_W-1:0];
              if (sum_c[TIME_W] || (sum_c[TIME_W-1:0] <= t_q)) begin
                err_d   = 1'b1;
                state_d = DONE;
              end
            end
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything; the error flag survives it.
    if (ctrl.flush) begin
      state_d = IDLE;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      cv_d    = '0;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      t_q      <= '0;
      nf_q     <= '0;
      base_q   <= '0;
      stride_q <= '0;
      ext_q    <= '0;
      idx_q    <= '0;
      cv_q     <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      nf_q     <= nf_d;
      base_q   <= base_d;
      stride_q <= stride_d;
      ext_q    <= ext_d;
      idx_q    <= idx_d;
      cv_q     <= cv_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign ctrl.en        = en_q;
  assign ctrl.ctrl_vars = cv_q;
  assign ctrl.busy      = busy_q;
  assign ctrl.done      = done_q;
  assign ctrl.cfg_err   = err_q;

endmodule

// File: tb/tb_ub_affine_op_controller.sv
// Bench for ub_affine_op_controller: vector table, hand-written corner sequences and random configs
// against an affine-formula reference model (stall sequence only when UB_CTRL_STALL_EN is defined).
module tb_ub_affine_op_controller;

  localparam int unsigned CTRL_W = 16;
  localparam int unsigned TIME_W = 32;

  typedef logic [2:0][CTRL_W-1:0] iv_t;
  typedef logic [2:0][TIME_W-1:0] st_t;
  typedef struct {
    iv_t               ext;
    st_t               str;
    logic [TIME_W-1:0] off;
    int                exp_fires;
    int                exp_done;
    bit                exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ub_affine_op_controller_if #(.CTRL_W(CTRL_W), .TIME_W(TIME_W)) ifc ();
  ub_affine_op_controller #(.CTRL_W(CTRL_W), .TIME_W(TIME_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ctrl (ifc)
  );

  int                tests = 0;
  int                fails = 0;
  iv_t               exp_cv;
  longint unsigned   m_time[$];
  iv_t               m_iv[$];
  bit                m_err;
  vec_t              tv[9];

  function automatic iv_t mk3(input int a, input int b, input int c);
    iv_t v;
    v[0] = CTRL_W'(a);
    v[1] = CTRL_W'(b);
    v[2] = CTRL_W'(c);
    return v;
  endfunction

  function automatic st_t mks(input longint unsigned a, input longint unsigned b, input longint unsigned c);
    st_t s;
    s[0] = TIME_W'(a);
    s[1] = TIME_W'(b);
    s[2] = TIME_W'(c);
    return s;
  endfunction

  function automatic void check(input string name, input longint unsigned got, input longint unsigned want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endfunction

  // Reference: iteration (a,b,c) fires at offset + a*s0 + b*s1 + c*s2 in lexicographic order;
  // a fire not strictly later than the previous one, or beyond 2^32-1, ends the run with an error.
  function automatic void build_model(input iv_t ext, input st_t str, input logic [TIME_W-1:0] off);
    longint unsigned tt;
    longint unsigned prev;
    iv_t v;
    m_time.delete();
    m_iv.delete();
    m_err = 1'b0;
    prev  = 0;
    for (int a = 0; a < int'(ext[0]); a++)
      for (int b = 0; b < int'(ext[1]); b++)
        for (int c = 0; c < int'(ext[2]); c++) begin
          tt = 64'(off) + 64'(a) * 64'(str[0]) + 64'(b) * 64'(str[1]) + 64'(c) * 64'(str[2]);
          if (m_time.size() > 0 && (tt <= prev || tt > 64'hFFFF_FFFF)) begin
            m_err = 1'b1;
            return;
          end
          v = mk3(a, b, c);
          m_time.push_back(tt);
          m_iv.push_back(v);
          prev = tt;
        end
  endfunction

  // Starts one run and compares the whole output trace, edge by edge, to the model (one comparison per run).
  task automatic run_cfg(input string tag, input iv_t ext, input st_t str, input logic [TIME_W-1:0] off,
                         input int flush_k, input int bogus_k, input int stall_k, input int stall_n,
                         input int tail, output int n_fires, output int done_k, output bit err_done);
    int              fe[$];
    int              last_k, dn_k, end_k, bog_k, j, kk;
    longint unsigned eff;
    bit              flushed, e_en, e_busy, e_done, e_err, stl, bad;
    logic [51:0]     got, want;

    build_model(ext, str, off);
    eff = 0;
    kk  = 1;
    j   = 0;
    while (j < m_time.size() && kk < 20000) begin
      stl = (kk >= stall_k) && (kk < stall_k + stall_n);
      if (!stl) begin
        if (eff == m_time[j]) begin
          fe.push_back(kk);
          j++;
        end
        eff++;
      end
      kk++;
    end
    last_k = (fe.size() > 0) ? fe[fe.size()-1] : 0;
    dn_k   = (fe.size() > 0) ? last_k + 1 : 2;
    end_k  = (flush_k > 0) ? flush_k + tail : dn_k + tail;
    bog_k  = (bogus_k <= dn_k) ? bogus_k : 0;

    @(negedge clk);
    ifc.start      = 1'b1;
    ifc.flush      = 1'b0;
    ifc.cfg_extent = ext;
    ifc.cfg_stride = str;
    ifc.cfg_offset = off;
    n_fires  = 0;
    done_k   = 0;
    err_done = 1'b0;
    j        = 0;
    e_err    = 1'b0;
    bad      = 1'b0;
    for (int k = 1; k <= end_k; k++) begin
      @(negedge clk);
      ifc.start = (k == bog_k);
      if (k == bog_k) begin
        ifc.cfg_extent = mk3(1, 1, 1);
        ifc.cfg_stride = '0;
        ifc.cfg_offset = '0;
      end
      ifc.flush = (k == flush_k);
`ifdef UB_CTRL_STALL_EN
      ifc.stall = (k >= stall_k) && (k < stall_k + stall_n);
`endif
      @(posedge clk);
      #1;
      flushed = (flush_k > 0) && (k >= flush_k);
      e_en    = !flushed && (j < fe.size()) && (fe[j] == k);
      if (e_en) begin
        exp_cv = m_iv[j];
        j++;
      end
      if (flushed) exp_cv = '0;
      e_busy = !flushed && (fe.size() > 0) && (k < dn_k);
      e_done = !flushed && (k == dn_k);
      if (!flushed && m_err && (k == last_k)) e_err = 1'b1;

      if (ifc.en) n_fires++;
      if (ifc.done) begin
        done_k   = k;
        err_done = ifc.cfg_err;
      end
      got  = {ifc.en, ifc.busy, ifc.done, ifc.cfg_err, ifc.ctrl_vars};
      want = {e_en, e_busy, e_done, e_err, exp_cv};
      if (got !== want && !bad) begin
        bad = 1'b1;
        $display("FAIL trace %s k=%0d got en,busy,done,err=%b%b%b%b cv=%h want %b%b%b%b cv=%h",
                 tag, k, got[51], got[50], got[49], got[48], got[47:0],
                 want[51], want[50], want[49], want[48], want[47:0]);
      end
    end
    tests++;
    if (bad) fails++;
  endtask

  initial begin
    iv_t               e;
    st_t               s;
    logic [TIME_W-1:0] o;
    int                nf, dk;
    bit                er;

    tv[0] = '{mk3(1, 2, 3),  mks(0, 10, 1),             32'd5, 6,    19,   1'b0};
    tv[1] = '{mk3(1, 2, 0),  mks(0, 10, 1),             32'd5, 0,    2,    1'b0};
    tv[2] = '{mk3(1, 2, 4),  mks(0, 5, 2),              32'd0, 4,    8,    1'b1};
    tv[3] = '{mk3(1, 64, 64), mks(0, 64, 1),            32'd0, 4096, 4097, 1'b0};
    tv[4] = '{mk3(1, 1, 1),  mks(7, 7, 7),              32'd0, 1,    2,    1'b0};
    tv[5] = '{mk3(1, 1, 2),  mks(0, 0, 0),              32'd3, 1,    5,    1'b1};
    tv[6] = '{mk3(2, 1, 1),  mks(64'hFFFF_FFFF, 0, 0),  32'd1, 1,    3,    1'b1};
    tv[7] = '{mk3(3, 1, 2),  mks(4, 0, 1),              32'd2, 6,    13,   1'b0};
    tv[8] = '{mk3(0, 5, 5),  mks(1, 1, 1),              32'd0, 0,    2,    1'b0};

    rst_n          = 1'b0;
    ifc.start      = 1'b0;
    ifc.flush      = 1'b0;
    ifc.cfg_extent = '0;
    ifc.cfg_stride = '0;
    ifc.cfg_offset = '0;
`ifdef UB_CTRL_STALL_EN
    ifc.stall      = 1'b0;
`endif
    exp_cv = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {ifc.en, ifc.busy, ifc.done, ifc.cfg_err, ifc.ctrl_vars}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_cfg($sformatf("vec%0d", i), tv[i].ext, tv[i].str, tv[i].off, 0, 0, 0, 0, 1, nf, dk, er);
      check($sformatf("vec%0d fires", i), 64'(nf), 64'(tv[i].exp_fires));
      check($sformatf("vec%0d done_k", i), 64'(dk), 64'(tv[i].exp_done));
      check($sformatf("vec%0d err", i), 64'(er), 64'(tv[i].exp_err));
    end

    // Back-to-back: second start lands right after the done pulse.
    run_cfg("b2b_first", tv[3].ext, tv[3].str, tv[3].off, 0, 0, 0, 0, 0, nf, dk, er);
    run_cfg("b2b_second", tv[0].ext, tv[0].str, tv[0].off, 0, 0, 0, 0, 1, nf, dk, er);
    check("b2b second fires", 64'(nf), 64'd6);

    run_cfg("flush_after_3", tv[0].ext, tv[0].str, tv[0].off, 9, 0, 0, 0, 3, nf, dk, er);
    check("flush fires", 64'(nf), 64'd3);
    check("flush no done", 64'(dk), 64'd0);

    run_cfg("start_while_busy", tv[0].ext, tv[0].str, tv[0].off, 0, 3, 0, 0, 1, nf, dk, er);
    check("busy start done_k", 64'(dk), 64'd19);
    run_cfg("start_in_done", tv[0].ext, tv[0].str, tv[0].off, 0, 19, 0, 0, 2, nf, dk, er);

    // Error flag survives a flush in IDLE, then clears on the next accepted start.
    run_cfg("viol_then_flush", tv[2].ext, tv[2].str, tv[2].off, 0, 0, 0, 0, 1, nf, dk, er);
    @(negedge clk);
    ifc.flush = 1'b1;
    @(posedge clk);
    #1;
    check("idle flush err kept", {ifc.en, ifc.busy, ifc.done, ifc.cfg_err}, 4'b0001);
    @(negedge clk);
    ifc.flush = 1'b0;
    exp_cv    = '0;
    run_cfg("err_cleared", tv[0].ext, tv[0].str, tv[0].off, 0, 0, 0, 0, 1, nf, dk, er);
    check("err cleared", 64'(er), 64'd0);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    ifc.start      = 1'b1;
    ifc.cfg_extent = tv[0].ext;
    ifc.cfg_stride = tv[0].str;
    ifc.cfg_offset = tv[0].off;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrun reset", {ifc.en, ifc.busy, ifc.done, ifc.cfg_err, ifc.ctrl_vars}, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    exp_cv = '0;

`ifdef UB_CTRL_STALL_EN
    run_cfg("stall3", tv[0].ext, tv[0].str, tv[0].off, 0, 0, 7, 3, 1, nf, dk, er);
    check("stall done_k", 64'(dk), 64'd22);
    check("stall fires", 64'(nf), 64'd6);
`endif

    for (int r = 0; r < 40; r++) begin
      for (int l = 0; l < 3; l++) begin
        e[l] = ($urandom_range(0, 11) == 0) ? CTRL_W'(0) : CTRL_W'($urandom_range(1, 4));
        s[l] = TIME_W'($urandom_range(0, 6));
      end
      o = TIME_W'($urandom_range(0, 12));
      run_cfg($sformatf("rand%0d", r), e, s, o, 0, int'($urandom_range(0, 12)), 0, 0,
              int'($urandom_range(0, 1)), nf, dk, er);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
